// File: rtl/dcache_miss_ctrl_if.sv
// Miss-controller port bundle: request/response, SRAM data/tag write port, burst bus master.
// master = the controller, slave = the cache pipeline / SRAM / bus side.
interface dcache_miss_ctrl_if #(
  parameter int WAY_NUM = 2,
  parameter int TAG_W   = 20
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [31:0]        req_paddr_i;
  logic [WAY_NUM-1:0] req_way_i;
  logic               req_dirty_i;
  logic [31:0]        req_victim_addr_i;
  logic [11:0]        sram_addr_o;
  logic [WAY_NUM-1:0] sram_way_o;
  logic [3:0]         sram_data_we_o;
  logic [31:0]        sram_wdata_o;
  logic [31:0]        sram_rdata_i;
  logic               sram_tag_we_o;
  logic [TAG_W+1:0]   sram_tag_o;
  logic               bus_req_valid_o;
  logic               bus_req_ready_i;
  logic               bus_req_write_o;
  logic [31:0]        bus_req_addr_o;
  logic               bus_wvalid_o;
  logic               bus_wready_i;
  logic [31:0]        bus_wdata_o;
  logic               bus_wlast_o;
  logic               bus_bvalid_i;
  logic               bus_rvalid_i;
  logic [31:0]        bus_rdata_i;
  logic               bus_rlast_i;
  logic               resp_valid_o;
  logic [31:0]        resp_word_o;
  logic               busy_o;

  modport master (
    input  req_valid_i, req_paddr_i, req_way_i, req_dirty_i, req_victim_addr_i,
    input  sram_rdata_i, bus_req_ready_i, bus_wready_i, bus_bvalid_i,
    input  bus_rvalid_i, bus_rdata_i, bus_rlast_i,
    output req_ready_o, sram_addr_o, sram_way_o, sram_data_we_o, sram_wdata_o,
    output sram_tag_we_o, sram_tag_o, bus_req_valid_o, bus_req_write_o, bus_req_addr_o,
    output bus_wvalid_o, bus_wdata_o, bus_wlast_o, resp_valid_o, resp_word_o, busy_o
  );

  modport slave (
    output req_valid_i, req_paddr_i, req_way_i, req_dirty_i, req_victim_addr_i,
    output sram_rdata_i, bus_req_ready_i, bus_wready_i, bus_bvalid_i,
    output bus_rvalid_i, bus_rdata_i, bus_rlast_i,
    input  req_ready_o, sram_addr_o, sram_way_o, sram_data_we_o, sram_wdata_o,
    input  sram_tag_we_o, sram_tag_o, bus_req_valid_o, bus_req_write_o, bus_req_addr_o,
    input  bus_wvalid_o, bus_wdata_o, bus_wlast_o, resp_valid_o, resp_word_o, busy_o
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// One dcache line miss: optional victim writeback, refill, tag write, critical word return.
// Clean miss 8 cycles accept-to-done on a zero-wait bus; bus valids hold until accepted, read beats always taken.
module dcache_miss_ctrl #(
  parameter int WAY_NUM    = 2,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 20
) (
  input logic              clk,
  input logic              rst,
  dcache_miss_ctrl_if.master mif
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFS = BW + 2;
  localparam logic [BW:0]   CNT_LW   = (BW+1)'(LINE_WORDS);
  localparam logic [BW:0]   CNT_END  = (BW+1)'(LINE_WORDS + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, WB_RD, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, TAG_WR, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BW:0]        cnt_q, cnt_d;
  logic [31:2]        paddr_q;
  logic [31:OFS]      vline_q;
  logic [WAY_NUM-1:0] way_q;
  logic [31:0]        wb_buf [LINE_WORDS];
  logic [31:0]        resp_word_q;
  logic [BW-1:0]      k, wb_idx, crit;

  // Low counter bits are the beat index; the top bit marks a full line in RF_DATA.
  assign k      = cnt_q[BW-1:0];
  assign wb_idx = k - BW'(1);
  assign crit   = paddr_q[OFS-1:2];

  assign mif.busy_o      = (state_q != IDLE);
  assign mif.resp_word_o = resp_word_q;

  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    mif.req_ready_o         = 1'b0;
    mif.sram_addr_o         = '0;
    mif.sram_way_o          = '0;
    mif.sram_data_we_o      = '0;
    mif.sram_wdata_o        = '0;
    mif.sram_tag_we_o       = 1'b0;
    mif.sram_tag_o          = '0;
    mif.bus_req_valid_o     = 1'b0;
    mif.bus_req_write_o     = 1'b0;
    mif.bus_req_addr_o      = '0;
    mif.bus_wvalid_o        = 1'b0;
    mif.bus_wdata_o         = '0;
    mif.bus_wlast_o         = 1'b0;
    mif.resp_valid_o        = 1'b0;
    case (state_q)
      IDLE: begin
        mif.req_ready_o = 1'b1;
        cnt_d           = '0;
        if (mif.req_valid_i) state_d = mif.req_dirty_i ? WB_RD : RF_REQ;
      end
      WB_RD: begin
        // Reads issue for LINE_WORDS cycles; data trails by one, plus one turnaround cycle.
        if (cnt_q < CNT_LW) begin
          mif.sram_addr_o = {vline_q[11:OFS], k, 2'b00};
          mif.sram_way_o  = way_q;
        end
        cnt_d = cnt_q + (BW+1)'(1);
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = WB_REQ;
        end
      end
      WB_REQ: begin
        mif.bus_req_valid_o = 1'b1;
        mif.bus_req_write_o = 1'b1;
        mif.bus_req_addr_o  = {vline_q, {OFS{1'b0}}};
        if (mif.bus_req_ready_i) state_d = WB_DATA;
      end
      WB_DATA: begin
        mif.bus_wvalid_o = 1'b1;
        mif.bus_wdata_o  = wb_buf[k];
        mif.bus_wlast_o  = (k == LAST_IDX);
        if (mif.bus_wready_i) begin
          if (k == LAST_IDX) begin
            cnt_d   = '0;
            state_d = WB_RESP;
          end else begin
            cnt_d = cnt_q + (BW+1)'(1);
          end
        end
      end
      WB_RESP: begin
        if (mif.bus_bvalid_i) state_d = RF_REQ;
      end
      RF_REQ: begin
        mif.bus_req_valid_o = 1'b1;
        mif.bus_req_addr_o  = {paddr_q[31:OFS], {OFS{1'b0}}};
        if (mif.bus_req_ready_i) begin
          cnt_d   = '0;
          state_d = RF_DATA;
        end
      end
      RF_DATA: begin
        if (mif.bus_rvalid_i) begin
          if (!cnt_q[BW]) begin
            mif.sram_addr_o    = {paddr_q[11:OFS], k, 2'b00};
            mif.sram_way_o     = way_q;
            mif.sram_data_we_o = 4'hF;
            mif.sram_wdata_o   = mif.bus_rdata_i;
            cnt_d              = cnt_q + (BW+1)'(1);
          end
          if (mif.bus_rlast_i) begin
            cnt_d   = '0;
            state_d = TAG_WR;
          end
        end
      end
      TAG_WR: begin
        mif.sram_tag_we_o = 1'b1;
        mif.sram_tag_o    = {paddr_q[31:32-TAG_W], 2'b10};
        state_d           = DONE;
      end
      DONE: begin
        mif.resp_valid_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      vline_q     <= '0;
      way_q       <= '0;
      resp_word_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) wb_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && mif.req_valid_i) begin
        paddr_q <= mif.req_paddr_i[31:2];
        vline_q <= mif.req_victim_addr_i[31:OFS];
        way_q   <= mif.req_way_i;
      end
      if (state_q == WB_RD && cnt_q != '0 && cnt_q <= CNT_LW)
        wb_buf[wb_idx] <= mif.sram_rdata_i;
      if (state_q == RF_DATA && mif.bus_rvalid_i && !cnt_q[BW] && k == crit)
        resp_word_q <= mif.bus_rdata_i;
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: clean/dirty misses, backpressure, read gaps, reset abort, back-to-back.
module tb_dcache_miss_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_miss_ctrl_if #(.WAY_NUM(2), .TAG_W(20)) mif ();
  dcache_miss_ctrl #(.WAY_NUM(2), .LINE_WORDS(4), .TAG_W(20)) dut (.clk(clk), .rst(rst), .mif(mif));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Victim line contents at index 0x23 of the SRAM.
  function automatic logic [31:0] vic_word(input logic [11:0] a);
    case (a)
      12'h230: return 32'h11;
      12'h234: return 32'h22;
      12'h238: return 32'h33;
      12'h23C: return 32'h44;
      default: return 32'hDEAD_0000 | {20'h0, a};
    endcase
  endfunction

  // Bus responder knobs
  int          req_wait = 0;
  int          bdelay   = 0;
  bit          wtoggle  = 0;
  logic [15:0] rmask    = 16'hF;
  logic [31:0] rbase    = '0;

  int          wcnt = 0, bcnt = 0, rc = 0, rk = 0;
  bit          pend_b = 0, rb_active = 0;
  logic [11:0] rd_addr = '0;

  always @(posedge clk) begin
    #2;
    mif.bus_bvalid_i = 1'b0;
    mif.bus_rvalid_i = 1'b0;
    mif.bus_rlast_i  = 1'b0;
    mif.bus_rdata_i  = '0;
    mif.sram_rdata_i = vic_word(rd_addr);
    if (rst) begin
      wcnt = 0; pend_b = 0; rb_active = 0; rc = 0; rk = 0;
      mif.bus_req_ready_i = 1'b0;
      mif.bus_wready_i    = 1'b0;
    end else begin
      if (pend_b) begin
        if (bcnt == 0) begin mif.bus_bvalid_i = 1'b1; pend_b = 0; end
        else bcnt--;
      end
      if (rb_active) begin
        if (rmask[rc]) begin
          mif.bus_rvalid_i = 1'b1;
          mif.bus_rdata_i  = rbase + 32'(rk);
          mif.bus_rlast_i  = (rk == 3);
          if (rk == 3) rb_active = 0;
          rk++;
        end
        rc++;
        if (rc > 15) rb_active = 0;
      end
      mif.bus_req_ready_i = 1'b0;
      if (mif.bus_req_valid_o) begin
        if (wcnt >= req_wait) begin
          mif.bus_req_ready_i = 1'b1;
          wcnt = 0;
          if (!mif.bus_req_write_o) begin rb_active = 1; rc = 0; rk = 0; end
        end else wcnt++;
      end
      mif.bus_wready_i = wtoggle ? ~mif.bus_wready_i : 1'b1;
      if (mif.bus_wvalid_o && mif.bus_wready_i && mif.bus_wlast_o) begin
        pend_b = 1; bcnt = bdelay;
      end
    end
  end

  // Event log
  int          acc_q[$], resp_cyc_q[$], wr_cyc_q[$], breq_cyc_q[$], b_cyc_q[$], rv_cyc_q[$];
  logic [31:0] accw_q[$], resp_w_q[$], wr_dat_q[$], breq_addr_q[$], wbeat_q[$];
  logic [11:0] wr_addr_q[$];
  logic [1:0]  wr_way_q[$];
  logic [3:0]  wr_we_q[$];
  logic        breq_wr_q[$], wlast_q[$];
  int          tag_n = 0;
  logic [21:0] tag_v = '0;
  logic        p_rq = 0, p_w = 0;
  logic [32:0] p_req = '0, p_wb = '0;

  always @(negedge clk) begin
    rd_addr = mif.sram_addr_o;
    if (!rst) begin
      if (mif.req_valid_i && mif.req_ready_o) begin acc_q.push_back(cyc); accw_q.push_back(mif.resp_word_o); end
      if (mif.sram_data_we_o != 4'h0) begin
        wr_cyc_q.push_back(cyc); wr_addr_q.push_back(mif.sram_addr_o);
        wr_way_q.push_back(mif.sram_way_o); wr_dat_q.push_back(mif.sram_wdata_o);
        wr_we_q.push_back(mif.sram_data_we_o);
      end
      if (mif.sram_tag_we_o) begin tag_n++; tag_v = mif.sram_tag_o; end
      if ((mif.sram_data_we_o != 4'h0) || mif.sram_tag_we_o)
        check("we_excl", (mif.sram_data_we_o != 4'h0) && mif.sram_tag_we_o, 0);
      if (mif.bus_req_valid_o && mif.bus_req_ready_i) begin
        breq_cyc_q.push_back(cyc); breq_addr_q.push_back(mif.bus_req_addr_o);
        breq_wr_q.push_back(mif.bus_req_write_o);
      end
      if (mif.bus_wvalid_o && mif.bus_wready_i) begin wbeat_q.push_back(mif.bus_wdata_o); wlast_q.push_back(mif.bus_wlast_o); end
      if (mif.bus_bvalid_i) b_cyc_q.push_back(cyc);
      if (mif.bus_rvalid_i) rv_cyc_q.push_back(cyc);
      if (mif.resp_valid_o) begin resp_cyc_q.push_back(cyc); resp_w_q.push_back(mif.resp_word_o); end
      if (p_rq) check("req_hold", {mif.bus_req_valid_o, mif.bus_req_write_o, mif.bus_req_addr_o}, {1'b1, p_req});
      if (p_w)  check("w_hold", {mif.bus_wvalid_o, mif.bus_wlast_o, mif.bus_wdata_o}, {1'b1, p_wb});
    end
    p_rq  = !rst && mif.bus_req_valid_o && !mif.bus_req_ready_i;
    p_req = {mif.bus_req_write_o, mif.bus_req_addr_o};
    p_w   = !rst && mif.bus_wvalid_o && !mif.bus_wready_i;
    p_wb  = {mif.bus_wlast_o, mif.bus_wdata_o};
  end

  task automatic clr();
    acc_q.delete(); accw_q.delete(); resp_cyc_q.delete(); resp_w_q.delete();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_way_q.delete(); wr_dat_q.delete(); wr_we_q.delete();
    breq_cyc_q.delete(); breq_addr_q.delete(); breq_wr_q.delete();
    wbeat_q.delete(); wlast_q.delete(); b_cyc_q.delete(); rv_cyc_q.delete();
    tag_n = 0; tag_v = '0;
  endtask

  task automatic issue(input logic [31:0] pa, input logic [1:0] way, input logic dirty, input logic [31:0] va);
    int n0;
    int t;
    @(posedge clk); #1;
    n0 = acc_q.size();
    mif.req_valid_i = 1'b1; mif.req_paddr_i = pa; mif.req_way_i = way;
    mif.req_dirty_i = dirty; mif.req_victim_addr_i = va;
    t = 0;
    while (acc_q.size() == n0 && t < 100) begin @(negedge clk); t++; end
    check("accept_in_time", acc_q.size() > n0, 1);
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int t;
    t = 0;
    while (resp_cyc_q.size() < n && t < 300) begin @(negedge clk); t++; end
    check("resp_in_time", resp_cyc_q.size() >= n, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_line(input string tag, input logic [11:0] base, input logic [1:0] way, input logic [31:0] d0);
    check({tag, "_nwr"}, wr_addr_q.size(), 4);
    for (int k = 0; k < wr_addr_q.size() && k < 4; k++) begin
      check({tag, "_waddr"}, wr_addr_q[k], base + 12'(4 * k));
      check({tag, "_wway"}, wr_way_q[k], way);
      check({tag, "_wdat"}, wr_dat_q[k], d0 + 32'(k));
      check({tag, "_wwe"}, wr_we_q[k], 4'hF);
    end
  endtask

  initial begin
    automatic int gap[4] = '{0, 2, 5, 6};
    automatic logic [31:0] vic_exp[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    mif.req_valid_i = 0; mif.req_paddr_i = '0; mif.req_way_i = '0; mif.req_dirty_i = 0;
    mif.req_victim_addr_i = '0; mif.sram_rdata_i = '0; mif.bus_req_ready_i = 0;
    mif.bus_wready_i = 0; mif.bus_bvalid_i = 0; mif.bus_rvalid_i = 0;
    mif.bus_rdata_i = '0; mif.bus_rlast_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", mif.req_ready_o, 1);
    check("rst_busy", mif.busy_o, 0);
    check("rst_breq", mif.bus_req_valid_o, 0);
    check("rst_wvalid", mif.bus_wvalid_o, 0);
    check("rst_we", {mif.sram_data_we_o, mif.sram_tag_we_o}, 0);
    check("rst_resp", {mif.resp_valid_o, mif.resp_word_o}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Clean miss
    clr(); rbase = 32'hA0;
    issue(32'h0000_1238, 2'b10, 1'b0, 32'h0);
    wait_resp(1);
    chk_line("clean", 12'h230, 2'b10, 32'hA0);
    check("clean_tagn", tag_n, 1);
    check("clean_tag", tag_v, 22'h000006);
    check("clean_word", resp_w_q[0], 32'hA2);
    check("clean_lat", resp_cyc_q[0] - acc_q[0] + 1, 8);
    check("clean_npulse", resp_cyc_q.size(), 1);
    check("clean_breq", {breq_wr_q[0], breq_addr_q[0]}, {1'b0, 32'h0000_1230});

    // Dirty miss, write response delayed by 2 cycles
    clr(); rbase = 32'hB0; bdelay = 2;
    issue(32'h0000_5238, 2'b01, 1'b1, 32'h8000_0230);
    wait_resp(1);
    bdelay = 0;
    check("dirty_nreq", breq_addr_q.size(), 2);
    check("dirty_wbreq", {breq_wr_q[0], breq_addr_q[0]}, {1'b1, 32'h8000_0230});
    check("dirty_rfreq", {breq_wr_q[1], breq_addr_q[1]}, {1'b0, 32'h0000_5230});
    check("dirty_nbeat", wbeat_q.size(), 4);
    for (int k = 0; k < wbeat_q.size() && k < 4; k++) begin
      check("dirty_wdat", wbeat_q[k], vic_exp[k]);
      check("dirty_wlast", wlast_q[k], k == 3);
    end
    check("dirty_rf_after_b", breq_cyc_q[1] - b_cyc_q[0], 1);
    check("dirty_lat", resp_cyc_q[0] - acc_q[0] + 1, 22);
    chk_line("dirty", 12'h230, 2'b01, 32'hB0);
    check("dirty_word", resp_w_q[0], 32'hB2);

    // Backpressure: request held 3 cycles, wready toggling
    clr(); rbase = 32'hC0; req_wait = 3; wtoggle = 1;
    issue(32'h0000_7234, 2'b10, 1'b1, 32'h8000_0230);
    wait_resp(1);
    req_wait = 0; wtoggle = 0;
    check("bp_wb_hs", breq_cyc_q[0] - acc_q[0], 10);
    check("bp_nbeat", wbeat_q.size(), 4);
    for (int k = 0; k < wbeat_q.size() && k < 4; k++) begin
      check("bp_wdat", wbeat_q[k], vic_exp[k]);
      check("bp_wlast", wlast_q[k], k == 3);
    end
    check("bp_word", resp_w_q[0], 32'hC1);

    // Read beats with gaps on cycles 0,2,5,6
    clr(); rbase = 32'hD0; rmask = 16'b110_0101;
    issue(32'h0000_300C, 2'b01, 1'b0, 32'h0);
    wait_resp(1);
    rmask = 16'hF;
    chk_line("gap", 12'h000, 2'b01, 32'hD0);
    check("gap_nrv", rv_cyc_q.size(), 4);
    for (int k = 0; k < wr_cyc_q.size() && k < 4 && k < rv_cyc_q.size(); k++) begin
      check("gap_beatcyc", wr_cyc_q[k], rv_cyc_q[k]);
      check("gap_spacing", wr_cyc_q[k] - wr_cyc_q[0], gap[k]);
    end
    check("gap_tag", tag_v, 22'h00000E);
    check("gap_word", resp_w_q[0], 32'hD3);

    // Reset in the middle of the refill burst
    clr(); rbase = 32'h50; rmask = 16'b100_0001;
    issue(32'h0000_4238, 2'b01, 1'b0, 32'h0);
    begin
      int t;
      t = 0;
      while (wr_cyc_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
    end
    check("mrst_saw_beat", wr_cyc_q.size(), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_ready", mif.req_ready_o, 1);
    check("mrst_busy", mif.busy_o, 0);
    check("mrst_strobes", {mif.sram_data_we_o, mif.sram_tag_we_o, mif.bus_req_valid_o}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mrst_notag", tag_n, 0);
    check("mrst_noresp", resp_cyc_q.size(), 0);
    clr(); rmask = 16'hF; rbase = 32'hE0;
    issue(32'h0000_4234, 2'b01, 1'b0, 32'h0);
    wait_resp(1);
    check("mrst_word", resp_w_q[0], 32'hE1);
    check("mrst_tag", {tag_n[1:0], tag_v}, {2'd1, 22'h000012});

    // Back-to-back requests
    clr(); rbase = 32'hF0;
    issue(32'h0000_5230, 2'b10, 1'b0, 32'h0);
    issue(32'h0000_623C, 2'b01, 1'b0, 32'h0);
    wait_resp(2);
    check("b2b_nacc", acc_q.size(), 2);
    check("b2b_gap", acc_q[1] - acc_q[0], 8);
    check("b2b_after_done", acc_q[1] - resp_cyc_q[0], 1);
    check("b2b_word_a", resp_w_q[0], 32'hF0);
    check("b2b_word_held", accw_q[1], 32'hF0);
    check("b2b_word_b", resp_w_q[1], 32'hF3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
